// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative-latency HI/LO multiply/divide unit with mthi/mtlo and
//             mfhi/mflo access. Optional multiply-accumulate (op 11) is built
//             only when the macro MULDIV_MADD_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  muldiv_op,
    input  logic        unsigned_op,
    input  logic        mthilo,
    input  logic        hilo_sel,
    input  logic [1:0]  mfhilo,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hilo_out
);

    localparam logic [3:0] C_MUL_CYCLES = 4'd5;
    localparam logic [3:0] C_DIV_CYCLES = 4'd10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;
    logic [31:0] a_q,     a_d;
    logic [31:0] b_q,     b_d;
    logic [1:0]  op_q,    op_d;
    logic        uns_q,   uns_d;

    logic        w_op_valid;
    logic        w_start;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_quo_mag;
    logic [31:0] w_rem_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
`ifdef MULDIV_MADD_EN
    logic [63:0] w_acc;
`endif

    always_comb begin
        w_op_valid = 1'b0;
        case (muldiv_op)
            2'b01, 2'b10: w_op_valid = 1'b1;
`ifdef MULDIV_MADD_EN
            2'b11:        w_op_valid = 1'b1;
`endif
            default:      w_op_valid = 1'b0;
        endcase
    end

    assign busy     = (state_q == ST_RUN);
    assign w_start  = w_op_valid && !busy;
    assign md_stall = busy || w_start;

    always_comb begin
        case (mfhilo)
            2'b01:   hilo_out = hi_q;
            2'b10:   hilo_out = lo_q;
            default: hilo_out = 32'h0;
        endcase
    end

    // Sign/zero extension to 64 bits makes one product serve both signednesses.
    assign w_a_ext = uns_q ? {32'h0, a_q} : {{32{a_q[31]}}, a_q};
    assign w_b_ext = uns_q ? {32'h0, b_q} : {{32{b_q[31]}}, b_q};
    assign w_prod  = w_a_ext * w_b_ext;
`ifdef MULDIV_MADD_EN
    assign w_acc   = {hi_q, lo_q} + w_prod;
`endif

    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000.
    assign w_a_neg   = !uns_q && a_q[31];
    assign w_b_neg   = !uns_q && b_q[31];
    assign w_a_mag   = w_a_neg ? -a_q : a_q;
    assign w_b_mag   = w_b_neg ? -b_q : b_q;
    assign w_quo_mag = w_a_mag / w_b_mag;
    assign w_rem_mag = w_a_mag % w_b_mag;
    assign w_quo     = (w_a_neg ^ w_b_neg) ? -w_quo_mag : w_quo_mag;
    assign w_rem     = w_a_neg ? -w_rem_mag : w_rem_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        uns_d   = uns_q;
        if (state_q == ST_IDLE) begin
            if (w_start) begin
                a_d     = a;
                b_d     = b;
                op_d    = muldiv_op;
                uns_d   = unsigned_op;
                cnt_d   = (muldiv_op == 2'b10) ? C_DIV_CYCLES : C_MUL_CYCLES;
                state_d = ST_RUN;
            end else if (mthilo) begin
                if (hilo_sel) lo_d = a;
                else          hi_d = a;
            end
        end else begin
            if (cnt_q == 4'd1) begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
                case (op_q)
                    2'b01: begin
                        hi_d = w_prod[63:32];
                        lo_d = w_prod[31:0];
                    end
                    2'b10: begin
                        if (b_q != 32'h0) begin
                            hi_d = w_rem;
                            lo_d = w_quo;
                        end
                    end
`ifdef MULDIV_MADD_EN
                    2'b11: begin
                        hi_d = w_acc[63:32];
                        lo_d = w_acc[31:0];
                    end
`endif
                    default: ;
                endcase
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            op_q    <= 2'b00;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            uns_q   <= uns_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-003 SHALL have port muldiv_op, input, 2, EX-stage operation: 00 none, 01 mult, 10 div, 11 madd (only with MULDIV_MADD_EN).
REQ-004 SHALL have port unsigned_op, input, 1, 1 = multu/divu/maddu semantics, 0 = signed.
REQ-005 SHALL have port mthilo, input, 1, move-to write request for HI/LO.
REQ-006 SHALL have port hilo_sel, input, 1, mthilo target: 0 = HI, 1 = LO.
REQ-007 SHALL have port mfhilo, input, 2, read select: 01 HI, 10 LO, others give zero.
REQ-008 SHALL have port a, input, 32, forwarded rs operand from EX.
REQ-009 SHALL have port b, input, 32, forwarded rt operand from EX.
REQ-010 SHALL have port busy, output, 1, high while an operation is in flight.
REQ-011 SHALL have port md_stall, output, 1, combinational busy OR start; the hazard unit stalls any mult/div/madd/mfhi/mflo/mthi/mtlo in ID while it is high.
REQ-012 SHALL have port hilo_out, output, 32, combinational value selected by mfhilo.

Function
REQ-013 SHALL define start as muldiv_op != 00 and busy == 0, with op 11 counting only when MULDIV_MADD_EN is defined.
REQ-014 SHALL latch a, b, op and unsigned_op on the start edge; later changes to a or b SHALL NOT affect the result.
REQ-015 SHALL run a down-counter FSM with states IDLE and RUN: start loads 5 for mult/madd or 10 for div and enters RUN; the counter decrements each cycle in RUN; when it reaches 1, HI/LO are written on that edge and the FSM returns to IDLE.
REQ-016 SHALL drive busy high exactly in cycles T+1..T+N for a start at edge T, with N = 5 or 10, so the result is readable in cycle T+N+1.
REQ-017 SHALL compute mult as the 64-bit product: signed two's-complement or unsigned per unsigned_op, HI = [63:32], LO = [31:0].
REQ-018 SHALL compute div as LO = quotient truncated toward zero and HI = remainder with the sign of the dividend; divu SHALL be unsigned.
REQ-019 SHALL give LO = 0x80000000 and HI = 0 for signed div of 0x80000000 by 0xFFFFFFFF.
REQ-020 SHALL leave HI and LO unchanged at completion when a div has b == 0, while still spending the full 10 busy cycles.
REQ-021 SHALL, when mthilo is high and neither start nor busy is active, write a into the register selected by hilo_sel on that edge.
REQ-022 SHALL give start priority over mthilo in the same cycle; the mthilo request is dropped.
REQ-023 SHALL ignore mthilo and new ops while busy is high; md_stall prevents these in correct operation.
REQ-024 SHALL drive hilo_out from the committed HI/LO, with no bypass of an in-flight result.

Reset
REQ-025 SHALL clear HI, LO, the counter, the latched operands and the FSM state (to IDLE) on reset, which drives busy = 0 and md_stall = start.
REQ-026 SHALL abort an in-flight operation when reset is asserted mid-operation, with no HI/LO write.

Configuration
REQ-027 SHALL gate madd support on the macro MULDIV_MADD_EN: when it is defined, op 11 takes 5 cycles and performs {HI,LO} += a*b (signed or unsigned per unsigned_op, 64-bit wrap-around).
REQ-028 SHALL treat op 11 exactly as op 00 when MULDIV_MADD_EN is not defined: no start, no busy and no md_stall contribution.

Verification
REQ-029 SHALL cover signed mult a=0xFFFFFFFE, b=3 -> busy for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-030 SHALL cover signed div a=-7 (0xFFFFFFF9), b=2 -> busy for 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF.
REQ-031 SHALL cover divu a=7, b=0 after mthi 0x11 and mtlo 0x22 -> 10 busy cycles, then HI=0x11 and LO=0x22.
REQ-032 SHALL cover multu a=b=0xFFFFFFFF with reset asserted in busy cycle 3 -> busy=0 on the next cycle and HI=LO=0.
REQ-033 SHALL cover mult and mthilo in the same cycle, followed by a second mult while busy -> only the first mult takes effect and md_stall stays high throughout.
REQ-034 SHALL cover, with MULDIV_MADD_EN defined, HI=0, LO=0xFFFFFFFF, then maddu a=1, b=1 -> HI=1 and LO=0; without the macro, the same op leaves HI/LO unchanged and busy=0.
